// File: rtl/calc_sequencer.sv
// Operand/opcode entry sequencer for a switch-driven ALU calculator.
// Walks A -> B -> OP -> EXEC -> SHOW and drives the display mux select.
module calc_sequencer #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter,
  input  logic             view,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] opnd_a,
  output logic [WIDTH-1:0] opnd_b,
  output logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [1:0]       disp_sel,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_GET_A,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_SHOW
  } state_t;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_RES = 2'b10;
  localparam logic [1:0] SEL_FLG = 2'b11;

  // Counter reload; EXEC ends when it reaches zero.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_a_q, opnd_a_d;
  logic [WIDTH-1:0] opnd_b_q, opnd_b_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [1:0]       disp_sel_q, disp_sel_d;
  logic [3:0]       wait_q, wait_d;
  logic             done_q, done_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_GET_A;
      opnd_a_q   <= '0;
      opnd_b_q   <= '0;
      opcode_q   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      disp_sel_q <= SEL_A;
      wait_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_a_q   <= opnd_a_d;
      opnd_b_q   <= opnd_b_d;
      opcode_q   <= opcode_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      disp_sel_q <= disp_sel_d;
      wait_q     <= wait_d;
      done_q     <= done_d;
    end
  end

  // Next-state, operand capture and display select.
  always_comb begin
    state_d    = state_q;
    opnd_a_d   = opnd_a_q;
    opnd_b_d   = opnd_b_q;
    opcode_d   = opcode_q;
    result_d   = result_q;
    flags_d    = flags_q;
    disp_sel_d = disp_sel_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_GET_A: begin
        if (enter) begin
          opnd_a_d   = data_in;
          state_d    = S_GET_B;
          disp_sel_d = SEL_B;
        end
      end
      S_GET_B: begin
        if (enter) begin
          opnd_b_d   = data_in;
          state_d    = S_GET_OP;
          disp_sel_d = SEL_B;
        end
      end
      S_GET_OP: begin
        if (enter) begin
          opcode_d   = op_in;
          wait_d     = LAT_M1;
          state_d    = S_EXEC;
          disp_sel_d = SEL_RES;
        end
      end
      S_EXEC: begin
        if (wait_q == 4'd0) begin
          result_d   = alu_result;
          flags_d    = alu_flags;
          done_d     = 1'b1;
          state_d    = S_SHOW;
          disp_sel_d = SEL_RES;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_SHOW: begin
        if (enter) begin
          state_d    = S_GET_A;
          disp_sel_d = SEL_A;
        end else if (view) begin
          disp_sel_d = (disp_sel_q == SEL_RES) ? SEL_FLG : SEL_RES;
        end
      end
      default: begin
        state_d    = S_GET_A;
        disp_sel_d = SEL_A;
      end
    endcase
  end

  assign opnd_a   = opnd_a_q;
  assign opnd_b   = opnd_b_q;
  assign opcode   = opcode_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign disp_sel = disp_sel_q;
  assign busy     = (state_q == S_EXEC);
  assign done     = done_q;

endmodule
